// File: rtl/i2c_cmd_queue.sv
// i2c_cmd_queue: command FIFO plus issue sequencer in front of the I2C test
// controller. Commands are queued, then handed to the controller one at a
// time over its execute/busy handshake; read bytes come back on rsp_*.
module i2c_cmd_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [6:0]       cmd_addr_i,
  input  logic             cmd_rw_i,
  input  logic [7:0]       cmd_reg_i,
  input  logic [7:0]       cmd_data_i,
  output logic [6:0]       ctl_address_o,
  output logic             ctl_rw_o,
  output logic [7:0]       ctl_register_o,
  output logic [7:0]       ctl_data_o,
  output logic             ctl_execute_o,
  input  logic             ctl_busy_i,
  input  logic [7:0]       ctl_rdata_i,
  output logic             rsp_valid_o,
  output logic [7:0]       rsp_reg_o,
  output logic [7:0]       rsp_data_o,
  output logic [PTR_W:0]   level_o,
  output logic             idle_o
);

  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] rg;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    ARM   = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  cmd_t             mem [DEPTH];
  cmd_t             cmd_in;
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   level_q;
  logic             push, pop, rsp_fire;

  assign cmd_in      = '{addr: cmd_addr_i, rw: cmd_rw_i, rg: cmd_reg_i, data: cmd_data_i};
  assign head        = mem[rd_ptr_q];
  // A full FIFO refuses pushes outright, even when the head leaves this cycle.
  assign cmd_ready_o = (level_q != FULL_LVL);
  assign push        = cmd_valid_i && cmd_ready_o && !rst_i;
  assign level_o     = level_q;
  assign idle_o      = (level_q == '0) && (state_q == IDLE) && !ctl_busy_i;

  // Entry storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= cmd_in;
  end

  // Pointers and occupancy; both pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake strobes. Execute is tied to ISSUE alone so a
  // falling busy can never re-trigger the controller.
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    rsp_fire      = 1'b0;
    ctl_execute_o = 1'b0;
    case (state_q)
      IDLE: begin
        if ((level_q != '0) && !ctl_busy_i) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ctl_execute_o = 1'b1;
        state_d       = ARM;
      end
      ARM: begin
        if (ctl_busy_i) state_d = RUN;
      end
      RUN: begin
        if (!ctl_busy_i) state_d = DONE;
      end
      DONE: begin
        rsp_fire = ctl_rw_o;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch: loaded only on the IDLE->ISSUE pop, held for the whole
  // transfer so the controller sees stable inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctl_address_o  <= '0;
      ctl_rw_o       <= 1'b0;
      ctl_register_o <= '0;
      ctl_data_o     <= '0;
    end else if (pop) begin
      ctl_address_o  <= head.addr;
      ctl_rw_o       <= head.rw;
      ctl_register_o <= head.rg;
      ctl_data_o     <= head.data;
    end
  end

  // Read response: one-cycle valid, payload held until the next read lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o <= 1'b0;
      rsp_reg_o   <= '0;
      rsp_data_o  <= '0;
    end else begin
      rsp_valid_o <= rsp_fire;
      if (rsp_fire) begin
        rsp_reg_o  <= ctl_register_o;
        rsp_data_o <= ctl_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Bench for i2c_cmd_queue: behavioural controller (busy one cycle after
// execute, high for 40 cycles), a queue-level scoreboard checked every cycle,
// and directed scenarios with literal expectations.
module tb_i2c_cmd_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = '0;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_reg = '0;
  logic [7:0] cmd_data = '0;
  logic [6:0] ctl_address;
  logic       ctl_rw;
  logic [7:0] ctl_register;
  logic [7:0] ctl_data;
  logic       ctl_execute;
  logic       ctl_busy;
  logic [7:0] ctl_rdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_reg;
  logic [7:0] rsp_data;
  logic [3:0] level;
  logic       idle;

  logic mbusy = 1'b0;
  logic force_busy = 1'b0;
  int   bcnt = 0;
  int   cyc = 0;

  assign ctl_busy = mbusy | force_busy;

  always #5 clk = ~clk;

  i2c_cmd_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_rw_i(cmd_rw), .cmd_reg_i(cmd_reg), .cmd_data_i(cmd_data),
    .ctl_address_o(ctl_address), .ctl_rw_o(ctl_rw), .ctl_register_o(ctl_register),
    .ctl_data_o(ctl_data), .ctl_execute_o(ctl_execute), .ctl_busy_i(ctl_busy),
    .ctl_rdata_i(ctl_rdata),
    .rsp_valid_o(rsp_valid), .rsp_reg_o(rsp_reg), .rsp_data_o(rsp_data),
    .level_o(level), .idle_o(idle)
  );

  // Controller model: busy rises the cycle after execute, lasts 40 cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ctl_execute === 1'b1) begin
      mbusy <= 1'b1;
      bcnt  <= 40;
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) mbusy <= 1'b0;
    end
  end

  typedef struct packed {
    logic [6:0] a;
    logic       rw;
    logic [7:0] r;
    logic [7:0] d;
  } cmd_t;

  cmd_t mq[$];
  cmd_t exec_log[$];
  cmd_t last_iss = '0;
  cmd_t pe;
  int   errors = 0, checks = 0;
  int   exec_cnt = 0, rsp_cnt = 0;
  int   last_push_cyc = 0, last_exec_cyc = 0, rsp_cyc = 0, fall_cyc = 0;
  int   quiet = 0, rd_phase = 0, fell_wait = 0;
  logic rd_pend = 1'b0;
  logic [7:0] rd_reg = '0, m_rsp_reg = '0, m_rsp_data = '0;
  logic prev_exec = 1'b0, prev_busy = 1'b0, armed = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard step, run once per cycle at the falling edge: compares the
  // outputs against the queue model, then applies what the next rising edge
  // will do (reset or accepted push).
  task monitor();
    if (armed) begin
      if (!ctl_busy && prev_busy) fall_cyc = cyc;
      quiet = (ctl_busy || ctl_execute) ? 0 : quiet + 1;
      if (ctl_execute) begin
        chk("exec_nonempty", 32'(mq.size() != 0), 1);
        chk("exec_width", prev_exec, 0);
        chk("exec_while_busy", ctl_busy, 0);
        if (mq.size() != 0) begin
          pe = mq.pop_front();
          chk("exec_operands", {ctl_address, ctl_rw, ctl_register, ctl_data}, pe);
          last_iss = pe;
          exec_log.push_back(pe);
          rd_pend  = pe.rw;
          rd_reg   = pe.r;
          rd_phase = 1;
        end
        exec_cnt++;
        last_exec_cyc = cyc;
      end
      if (rsp_valid) begin
        chk("rsp_expected", 32'(rd_pend && rd_phase == 3), 1);
        m_rsp_reg  = rd_reg;
        m_rsp_data = ctl_rdata;
        rsp_cnt++;
        rsp_cyc  = cyc;
        rd_pend  = 1'b0;
        rd_phase = 0;
      end else if (rd_phase == 1 && ctl_busy) begin
        rd_phase = 2;
      end else if (rd_phase == 2 && !ctl_busy) begin
        rd_phase  = 3;
        fell_wait = 0;
      end else if (rd_phase == 3) begin
        fell_wait++;
        if (rd_pend && fell_wait > 4) begin
          chk("rsp_missing", 0, 1);
          rd_pend  = 1'b0;
          rd_phase = 0;
        end
      end
      if (ctl_busy) chk("ctl_stable", {ctl_address, ctl_rw, ctl_register, ctl_data}, last_iss);
      chk("level", level, mq.size());
      chk("ready", cmd_ready, 32'(mq.size() != 8));
      chk("rsp_reg_hold", rsp_reg, m_rsp_reg);
      chk("rsp_data_hold", rsp_data, m_rsp_data);
      if (ctl_busy || mq.size() != 0) chk("idle_low", idle, 0);
      else if (quiet >= 3)            chk("idle_high", idle, 1);
    end
    prev_exec = ctl_execute;
    prev_busy = ctl_busy;
    if (rst) begin
      mq.delete();
      last_iss   = '0;
      m_rsp_reg  = '0;
      m_rsp_data = '0;
      rd_pend    = 1'b0;
      rd_phase   = 0;
      armed      = 1'b1;
    end else if (cmd_valid && mq.size() != 8) begin
      mq.push_back({cmd_addr, cmd_rw, cmd_reg, cmd_data});
      last_push_cyc = cyc;
    end
  endtask

  // One clock: scoreboard at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [6:0] a, input logic rw, input logic [7:0] r, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_addr = a; cmd_rw = rw; cmd_reg = r; cmd_data = d;
    tick();
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    repeat (3) tick();
    while (idle !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    if (n >= maxc) chk("wait_idle_timeout", 0, 1);
    repeat (2) tick();
  endtask

  initial begin
    int e0, r0, n;
    // Reset, with busy held so the idle term follows busy.
    force_busy = 1'b1;
    repeat (3) tick();
    chk("rst_level", level, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_exec", ctl_execute, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ctl", {ctl_address, ctl_rw, ctl_register, ctl_data}, 0);
    chk("rst_idle_busy", idle, 0);
    force_busy = 1'b0;
    #1;
    chk("rst_idle_free", idle, 1);
    rst = 1'b0;
    tick();

    // 1: single write, latency and operands.
    e0 = exec_cnt; r0 = rsp_cnt;
    put(7'h40, 1'b0, 8'h00, 8'h21);
    cmd_valid = 1'b0;
    wait_idle(200);
    chk("t1_exec_count", exec_cnt - e0, 1);
    chk("t1_latency", last_exec_cyc - last_push_cyc, 2);
    chk("t1_operands", exec_log[exec_log.size()-1], 24'h80_00_21 | (24'h40 << 17));
    chk("t1_no_rsp", rsp_cnt - r0, 0);

    // 2: eight back-to-back writes; head pops, so level settles at 7.
    e0 = exec_cnt;
    for (int i = 0; i < 8; i++) put(7'h50, 1'b0, 8'(i), 8'(8'h30 + i));
    cmd_valid = 1'b0;
    chk("t2_level", level, 7);
    chk("t2_ready", cmd_ready, 1);
    wait_idle(600);
    chk("t2_exec_count", exec_cnt - e0, 8);
    n = exec_log.size();
    for (int i = 0; i < 8; i++) chk("t2_order", exec_log[n-8+i].d, 32'h30 + i);

    // 3: controller held busy, nine pushes; the ninth is refused.
    e0 = exec_cnt;
    force_busy = 1'b1;
    for (int i = 0; i < 9; i++) put(7'h51, 1'b0, 8'h10, 8'(8'h60 + i));
    cmd_valid = 1'b0;
    chk("t3_level_full", level, 8);
    chk("t3_ready_low", cmd_ready, 0);
    force_busy = 1'b0;
    wait_idle(600);
    chk("t3_exec_count", exec_cnt - e0, 8);
    n = exec_log.size();
    for (int i = 0; i < 8; i++) chk("t3_order", exec_log[n-8+i].d, 32'h60 + i);

    // 4: read returning 0xA5.
    ctl_rdata = 8'hA5;
    r0 = rsp_cnt;
    put(7'h40, 1'b1, 8'h06, 8'h00);
    cmd_valid = 1'b0;
    wait_idle(200);
    chk("t4_rsp_count", rsp_cnt - r0, 1);
    chk("t4_rsp_reg", rsp_reg, 8'h06);
    chk("t4_rsp_data", rsp_data, 8'hA5);
    chk("t4_after_fall", 32'(rsp_cyc > fall_cyc), 1);

    // 5: external busy blocks issue.
    e0 = exec_cnt;
    force_busy = 1'b1;
    put(7'h22, 1'b0, 8'h01, 8'h02);
    cmd_valid = 1'b0;
    repeat (20) begin
      tick();
      chk("t5_idle_low", idle, 0);
    end
    chk("t5_no_exec", exec_cnt - e0, 0);
    force_busy = 1'b0;
    wait_idle(200);
    chk("t5_exec_after", exec_cnt - e0, 1);

    // 6: reset during RUN with three entries queued.
    for (int i = 0; i < 4; i++) put(7'h33, 1'b0, 8'h20, 8'(8'h70 + i));
    cmd_valid = 1'b0;
    n = 0;
    while (!ctl_busy && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("t6_busy_timeout", 0, 1);
    repeat (5) tick();
    chk("t6_level_before", level, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_level_after", level, 0);
    e0 = exec_cnt;
    repeat (80) tick();
    chk("t6_no_exec", exec_cnt - e0, 0);
    chk("t6_idle_end", idle, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
